port_io_agent: RTL
==================

PORT_IO_AGENT -- requirements
Module: port_io_agent

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, capture-FIFO entries; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 out_port1..out_port4  input  8 each  CPU output-port data.
REQ-005 out_strobe  input  4  CPU write pulse; bit n-1 qualifies out_portn.
REQ-006 in_port1..in_port4  output  8 each  CPU input-port data, driven from holding registers.
REQ-007 in_strobe  input  4  CPU read pulse; bit n-1 consumes in_portn.
REQ-008 tx_data  output  8  head-of-FIFO data toward the external consumer.
REQ-009 tx_port  output  2  head-of-FIFO port index (0..3 = port1..port4).
REQ-010 tx_valid  output  1  FIFO not empty.
REQ-011 tx_ready  input  1  consumer accepts the head entry.
REQ-012 rx_data  input  8  external producer data for an input port.
REQ-013 rx_port  input  2  target input-port index.
REQ-014 rx_valid  input  1  producer offers rx_data/rx_port.
REQ-015 rx_ready  output  1  target holding register is free.
REQ-016 in_full  output  4  holding-register occupied flags, bit n-1 for in_portn.
REQ-017 ovf  output  1  sticky flag set on any dropped CPU write.

Function
REQ-018 Capture: in a cycle with out_strobe nonzero, push {lowest set index, matching out_port} into the FIFO at the next edge.
REQ-019 Multiple out_strobe bits in one cycle: only the lowest index is pushed; the others are dropped and ovf is set.
REQ-020 Push when full without a same-cycle pop: the write is dropped, FIFO contents are unchanged, and ovf is set.
REQ-021 Push when full with a same-cycle pop (tx_valid && tx_ready): the push is accepted and occupancy stays at FIFO_DEPTH.
REQ-022 Pop: tx_valid && tx_ready advances the read pointer at the edge.
REQ-023 Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with an extra pointer bit or a counter, so full and empty are never ambiguous.
REQ-024 tx_data, tx_port and tx_valid reflect the head combinationally from registered state, with zero-cycle read latency.
REQ-025 While tx_valid is high and tx_ready is low, tx_data and tx_port are held stable.
REQ-026 Strobe-to-tx_valid latency is 1 cycle when the FIFO is empty; there is no bypass path.
REQ-027 rx_ready = ~in_full[rx_port], combinational.
REQ-028 rx_valid && rx_ready loads the holding register for rx_port and sets its in_full bit at the edge.
REQ-029 in_strobe bit n-1 high with in_full[n-1] set clears in_full[n-1]; the register value is retained on in_portn.
REQ-030 in_strobe on a port whose in_full bit is clear is ignored; a same-cycle load on that port wins.
REQ-031 Input and output paths are fully independent; all four ports operate concurrently.
REQ-032 ovf clears only on reset.

Reset
REQ-033 On rst low, asynchronously: FIFO empty and pointers 0, tx_valid=0, tx_data=0, tx_port=0.
REQ-034 On rst low, asynchronously: holding registers 0, in_port1..4=0, in_full=0, ovf=0.
REQ-035 With rst low, rx_ready=1 and all strobes are ignored.
REQ-036 Reset mid-transfer discards all FIFO contents and pending holds.
REQ-037 Reset deassertion is synchronous to clk by external convention; the first capture is possible on the first edge after release.

Configuration
REQ-038 Macro PORT_AGENT_DROPCNT_EN defined: adds output drop_cnt [7:0], counting every dropped write (one per dropped strobe bit), saturating at 255, reset to 0.
REQ-039 Macro PORT_AGENT_DROPCNT_EN undefined: the drop_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-040 Single write: out_strobe=4'b0010, out_port2=8'hA5, tx_ready=1 -> one cycle later tx_valid=1, tx_port=1, tx_data=A5; next cycle tx_valid=0.
REQ-041 Fill and overflow (FIFO_DEPTH=4, tx_ready=0): 5 strobes on port1 with data 01..05 -> 4 entries held, ovf=1; then draining yields 01,02,03,04 in order (drop_cnt=1 if enabled).
REQ-042 Collision: out_strobe=4'b1010 -> only port2 entry captured, ovf=1 (drop_cnt=1 if enabled).
REQ-043 Full with simultaneous push/pop: FIFO full, tx_ready=1, strobe port3 data 8'h3C -> no drop, occupancy stays 4, 3C appears last after wrap.
REQ-044 Input path: rx_port=2, rx_data=8'h77, rx_valid=1 -> in_port3=77, in_full=4'b0100, rx_ready=0 for port 2; in_strobe=4'b0100 -> in_full=0, in_port3 stays 77.
REQ-045 Async reset mid-stream with 3 entries queued: rst low between edges -> tx_valid=0, in_full=0, ovf=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/port_io_agent.sv
// Four-port CPU I/O agent: strobed output writes go into a capture FIFO toward tx_*,
// and rx_* loads per-port input holding registers. Optional drop counter: PORT_AGENT_DROPCNT_EN.
module port_io_agent #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] out_port1,
    input  logic [7:0] out_port2,
    input  logic [7:0] out_port3,
    input  logic [7:0] out_port4,
    input  logic [3:0] out_strobe,
    output logic [7:0] in_port1,
    output logic [7:0] in_port2,
    output logic [7:0] in_port3,
    output logic [7:0] in_port4,
    input  logic [3:0] in_strobe,
    output logic [7:0] tx_data,
    output logic [1:0] tx_port,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic [1:0] rx_port,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [3:0] in_full,
    output logic       ovf
`ifdef PORT_AGENT_DROPCNT_EN
    ,
    output logic [7:0] drop_cnt
`endif
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FullDiff = {1'b1, {AW{1'b0}}};

    // Entry layout: {port index, data}
    logic [9:0]  mem_q [FIFO_DEPTH];
    logic [9:0]  mem_d [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  hold_q [4];
    logic [7:0]  hold_d [4];
    logic [3:0]  full_q, full_d;

    logic       fifo_full, pop, push_req, push_ok, drop_any;
    logic [1:0] sel_idx;
    logic [7:0] sel_data;
    logic [2:0] n_set;
    logic [9:0] head;
    logic       rx_load;

    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign tx_valid  = (wr_ptr_q != rd_ptr_q);
    assign tx_data   = tx_valid ? head[7:0] : 8'h00;
    assign tx_port   = tx_valid ? head[9:8] : 2'd0;
    assign fifo_full = ((wr_ptr_q ^ rd_ptr_q) == FullDiff);
    assign pop       = tx_valid && tx_ready;
    assign push_req  = |out_strobe;
    assign push_ok   = push_req && (!fifo_full || pop);

    always_comb begin
        sel_idx = 2'd0;
        n_set   = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (out_strobe[i]) sel_idx = 2'(i);
        end
        for (int i = 0; i < 4; i++) begin
            n_set = n_set + {2'b00, out_strobe[i]};
        end
        unique case (sel_idx)
            2'd0:    sel_data = out_port1;
            2'd1:    sel_data = out_port2;
            2'd2:    sel_data = out_port3;
            default: sel_data = out_port4;
        endcase
    end

    // Extra strobe bits are lost even when the lowest one is accepted
    assign drop_any = (push_req && !push_ok) || (n_set > 3'd1);

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q || drop_any;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = {sel_idx, sel_data};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    assign rx_ready = ~full_q[rx_port];
    assign rx_load  = rx_valid && rx_ready;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hold_d[i] = hold_q[i];
            full_d[i] = full_q[i];
            // A same-cycle load outranks the read strobe on the same port
            if (rx_load && (rx_port == 2'(i))) begin
                hold_d[i] = rx_data;
                full_d[i] = 1'b1;
            end else if (in_strobe[i] && full_q[i]) begin
                full_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            for (int i = 0; i < 4; i++) hold_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            full_q   <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
            for (int i = 0; i < 4; i++) hold_q[i] <= hold_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            full_q   <= full_d;
        end
    end

    assign in_port1 = hold_q[0];
    assign in_port2 = hold_q[1];
    assign in_port3 = hold_q[2];
    assign in_port4 = hold_q[3];
    assign in_full  = full_q;
    assign ovf      = ovf_q;

`ifdef PORT_AGENT_DROPCNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [2:0] n_drop;
    logic [8:0] cnt_sum;

    always_comb begin
        n_drop     = push_ok ? (n_set - 3'd1) : n_set;
        cnt_sum    = {1'b0, drop_cnt_q} + {6'd0, n_drop};
        drop_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_cnt_q <= 8'h00;
        else      drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
